// File: rtl/serial_uart_bridge_pkg.sv
// serial_uart_bridge_pkg: shared UART FSM state encoding and line idle level
package serial_uart_bridge_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;
  localparam logic UART_IDLE = 1'b1;
endpackage

// File: rtl/serial_uart_bridge_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with count-derived full/empty, head reads 0 when empty
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    push = wr_en && !full;
    pop = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: processor serial-port responder bridging TX/RX byte FIFOs to an 8N1 UART line
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_data_in,
  input  logic       proc_wren_in,
  input  logic       proc_rden_in,
  output logic [7:0] proc_data_out,
  output logic       proc_valid_out,
  output logic       proc_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  import serial_uart_bridge_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_head;
  logic [1:0] sync_q, sync_d;
  logic tx_q, tx_d, rx_bad_q, rx_bad_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic tx_pop, rx_push, tx_full, tx_empty, rx_full, rx_empty, rx_s;
  logic [FCW-1:0] tx_count_unused, rx_count_unused;
  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clock(clock), .reset(reset), .wr_en(proc_wren_in), .wr_data(proc_data_in),
    .rd_en(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count_unused)
  );
  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clock(clock), .reset(reset), .wr_en(rx_push), .wr_data(rx_shift_q),
    .rd_en(proc_rden_in), .rd_data(proc_data_out), .full(rx_full), .empty(rx_empty), .count(rx_count_unused)
  );
  assign proc_ready_out = !tx_full;
  assign proc_valid_out = !rx_empty;
  assign uart_tx_out = tx_q;
  assign rx_overrun_out = overrun_q;
  assign rx_frame_err_out = frame_err_q;
  assign rx_s = sync_q[1];
  assign sync_d = {sync_q[0], uart_rx_in};
  // STOP chains straight into the next START so queued bytes leave with no idle gap
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_idx_d = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop = 1'b0;
    tx_d = tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_shift_q[0] : UART_IDLE;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_idx_d = tx_idx_q + 1'b1;
        tx_state_d = tx_idx_q == 3'd7 ? S_STOP : S_DATA;
      end
      S_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_pop = !tx_empty;
        tx_shift_d = tx_empty ? tx_shift_q : tx_head;
        tx_state_d = tx_empty ? S_IDLE : S_START;
      end
    endcase
  end
  // rx_bad marks a low stop bit: hold in STOP, byte discarded, until the line recovers
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_idx_d = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_bad_d = rx_bad_q;
    rx_push = 1'b0;
    overrun_d = overrun_q;
    frame_err_d = frame_err_q;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_state_d = rx_s ? S_IDLE : S_START;
      end
      S_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_idx_d = rx_idx_q + 1'b1;
        rx_state_d = rx_idx_q == 3'd7 ? S_STOP : S_DATA;
      end
      S_STOP: if (rx_bad_q) begin
        rx_bad_d = !rx_s;
        rx_state_d = rx_s ? S_IDLE : S_STOP;
      end else if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_push = rx_s;
        overrun_d = overrun_q || (rx_s && rx_full);
        frame_err_d = frame_err_q || !rx_s;
        rx_bad_d = !rx_s;
        rx_state_d = rx_s ? S_IDLE : S_STOP;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_shift_q <= '0;
      tx_q <= UART_IDLE;
      rx_state_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_shift_q <= '0;
      rx_bad_q <= 1'b0;
      sync_q <= {2{UART_IDLE}};
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_idx_q <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_bad_q <= rx_bad_d;
      sync_q <= sync_d;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb_serial_uart_bridge: directed plus random checks of the bridge against a queue-based UART/FIFO model
module tb_serial_uart_bridge;
  localparam int N = 4;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] proc_data_in = '0;
  logic proc_wren_in = 1'b0;
  logic proc_rden_in = 1'b0;
  logic uart_rx_in = 1'b1;
  logic [7:0] proc_data_out;
  logic proc_valid_out, proc_ready_out, uart_tx_out, rx_overrun_out, rx_frame_err_out;
  int checks = 0;
  int passes = 0;
  int tx_lvl;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic ovr_exp = 1'b0;
  logic ferr_exp = 1'b0;
  logic [7:0] b, b2;
  serial_uart_bridge #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .proc_data_in(proc_data_in), .proc_wren_in(proc_wren_in),
    .proc_rden_in(proc_rden_in), .proc_data_out(proc_data_out), .proc_valid_out(proc_valid_out),
    .proc_ready_out(proc_ready_out), .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
    .rx_overrun_out(rx_overrun_out), .rx_frame_err_out(rx_frame_err_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic write_byte(input logic [7:0] v);
    proc_data_in = v;
    proc_wren_in = 1'b1;
    tick();
    proc_wren_in = 1'b0;
  endtask
  task automatic read_byte();
    check("rd_valid", proc_valid_out, 1'b1);
    check("rd_data", proc_data_out, rx_exp[0]);
    proc_rden_in = 1'b1;
    tick();
    proc_rden_in = 1'b0;
    void'(rx_exp.pop_front());
  endtask
  task automatic tx_expect(input int n);
    logic [7:0] f;
    tick();
    check("tx_pre_start", uart_tx_out, 1'b1);
    for (int k = 0; k < n; k++) begin
      f = tx_exp.pop_front();
      for (int j = 0; j < 10; j++)
        for (int c = 0; c < N; c++) begin
          tick();
          check("tx_bit", uart_tx_out, (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : f[j-1]);
        end
    end
  endtask
  task automatic rx_frame(input logic [7:0] v, input logic stop);
    for (int j = 0; j < 10; j++) begin
      uart_rx_in = (j == 0) ? 1'b0 : (j == 9) ? stop : v[j-1];
      repeat (N) tick();
    end
    uart_rx_in = 1'b1;
    repeat (6) tick();
    if (!stop) ferr_exp = 1'b1;
    else if (rx_exp.size() < D) rx_exp.push_back(v);
    else ovr_exp = 1'b1;
  endtask
  task automatic rx_status(input string tag);
    check({tag, "_valid"}, proc_valid_out, rx_exp.size() != 0);
    if (rx_exp.size() != 0) check({tag, "_data"}, proc_data_out, rx_exp[0]);
    check({tag, "_overrun"}, rx_overrun_out, ovr_exp);
    check({tag, "_frame_err"}, rx_frame_err_out, ferr_exp);
  endtask
  initial begin
    repeat (2) tick();
    check("rst_tx", uart_tx_out, 1'b1);
    check("rst_ready", proc_ready_out, 1'b1);
    check("rst_valid", proc_valid_out, 1'b0);
    check("rst_data", proc_data_out, 8'h00);
    check("rst_overrun", rx_overrun_out, 1'b0);
    check("rst_frame_err", rx_frame_err_out, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_tx", uart_tx_out, 1'b1);
      check("idle_valid", proc_valid_out, 1'b0);
    end
    tx_exp.push_back(8'hA5);
    write_byte(8'hA5);
    tx_expect(1);
    repeat (4) tick();
    b = 8'($urandom);
    tx_exp.push_back(b);
    write_byte(b);
    fork
      tx_expect(D + 1);
      begin
        repeat (3) tick();
        tx_lvl = 0;
        for (int i = 0; i < 5; i++) begin
          b2 = 8'($urandom);
          if (tx_lvl < D) begin
            tx_exp.push_back(b2);
            tx_lvl++;
          end
          write_byte(b2);
          check("burst_ready", proc_ready_out, tx_lvl < D);
        end
      end
    join
    tick();
    check("tx_drained", uart_tx_out, 1'b1);
    check("tx_ready_back", proc_ready_out, 1'b1);
    rx_frame(8'h3C, 1'b1);
    rx_status("rx3c");
    read_byte();
    rx_status("rx3c_popped");
    uart_rx_in = 1'b0;
    tick();
    uart_rx_in = 1'b1;
    repeat (12) tick();
    rx_status("glitch");
    for (int i = 0; i < 5; i++) begin
      rx_frame(8'($urandom), 1'b1);
      rx_status("rx_fill");
    end
    while (rx_exp.size() != 0) read_byte();
    rx_status("rx_drained");
    rx_frame(8'($urandom), 1'b0);
    rx_status("rx_bad_stop");
    rx_frame(8'($urandom), 1'b1);
    rx_status("rx_after_bad");
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    repeat (15) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_tx", uart_tx_out, 1'b1);
    check("midrst_ready", proc_ready_out, 1'b1);
    check("midrst_valid", proc_valid_out, 1'b0);
    check("midrst_data", proc_data_out, 8'h00);
    check("midrst_overrun", rx_overrun_out, 1'b0);
    check("midrst_frame_err", rx_frame_err_out, 1'b0);
    tx_exp.delete();
    rx_exp.delete();
    ovr_exp = 1'b0;
    ferr_exp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("postrst_tx", uart_tx_out, 1'b1);
    end
    for (int i = 0; i < 2; i++) rx_frame(8'($urandom), 1'b1);
    rx_status("rx_two");
    b = 8'($urandom);
    tx_exp.push_back(b);
    write_byte(b);
    fork
      tx_expect(D + 1);
      begin
        repeat (3) tick();
        for (int i = 0; i < D; i++) begin
          b2 = 8'($urandom);
          tx_exp.push_back(b2);
          write_byte(b2);
        end
        check("full_ready", proc_ready_out, 1'b0);
        proc_data_in = 8'($urandom);
        proc_wren_in = 1'b1;
        proc_rden_in = 1'b1;
        tick();
        proc_wren_in = 1'b0;
        proc_rden_in = 1'b0;
        void'(rx_exp.pop_front());
        check("both_ready", proc_ready_out, 1'b0);
        rx_status("both_rx");
        read_byte();
        rx_status("both_rx_empty");
      end
    join
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
